// File: rtl/poly_mult_pkg.sv
// Shared types and size helpers for the polynomial tile feeder.
package poly_mult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } feeder_state_e;

  function automatic int num_tiles(input int poly_w, input int tile_w);
    return poly_w / tile_w;
  endfunction

  // A single-tile polynomial still needs a 1-bit index so ports never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/poly_tile_feeder_idx_counter.sv
// Nested tile-pair index counter: B index is the inner loop, A index the outer.
module tile_idx_counter #(
  parameter int NA = 2,
  parameter int NB = 2,
  parameter int AW = 1,
  parameter int BW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance_i,
  input  logic          clear_i,
  output logic [AW-1:0] a_idx_o,
  output logic [BW-1:0] b_idx_o,
  output logic          last_o
);

  logic [AW-1:0] a_idx_q, a_idx_d;
  logic [BW-1:0] b_idx_q, b_idx_d;
  logic          a_at_end, b_at_end;

  assign a_at_end = (a_idx_q == AW'(NA - 1));
  assign b_at_end = (b_idx_q == BW'(NB - 1));

  // Clear wins over advance so a finished sweep always restarts at pair (0,0).
  always_comb begin
    a_idx_d = a_idx_q;
    b_idx_d = b_idx_q;
    if (clear_i) begin
      a_idx_d = '0;
      b_idx_d = '0;
    end else if (advance_i) begin
      if (b_at_end) begin
        b_idx_d = '0;
        a_idx_d = a_at_end ? '0 : a_idx_q + AW'(1);
      end else begin
        b_idx_d = b_idx_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_idx_q <= '0;
      b_idx_q <= '0;
    end else begin
      a_idx_q <= a_idx_d;
      b_idx_q <= b_idx_d;
    end
  end

  assign a_idx_o = a_idx_q;
  assign b_idx_o = b_idx_q;
  assign last_o  = a_at_end && b_at_end;

endmodule

// File: rtl/poly_tile_feeder.sv
// Sweeps every (A tile, B tile) pair: fetches both tiles from memory, registers them
// and hands each pair to the multiplier, waiting for its completion before moving on.
module poly_tile_feeder
  import poly_mult_pkg::*;
#(
  parameter int POLY_A_WIDTH      = 128,
  parameter int POLY_B_WIDTH      = 128,
  parameter int POLY_A_TILE_WIDTH = 8,
  parameter int POLY_B_TILE_WIDTH = 8,
  parameter int DATA_WIDTH        = 64,
  localparam int NA = num_tiles(POLY_A_WIDTH, POLY_A_TILE_WIDTH),
  localparam int NB = num_tiles(POLY_B_WIDTH, POLY_B_TILE_WIDTH),
  localparam int AW = idx_width(NA),
  localparam int BW = idx_width(NB)
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  output logic                                         a_rd_en,
  output logic                                         b_rd_en,
  output logic [AW-1:0]                                a_rd_addr,
  output logic [BW-1:0]                                b_rd_addr,
  input  logic [POLY_A_TILE_WIDTH-1:0][DATA_WIDTH-1:0] a_rd_data,
  input  logic [POLY_B_TILE_WIDTH-1:0][DATA_WIDTH-1:0] b_rd_data,
  output logic [POLY_A_TILE_WIDTH-1:0][DATA_WIDTH-1:0] tile_a,
  output logic [POLY_B_TILE_WIDTH-1:0][DATA_WIDTH-1:0] tile_b,
  output logic                                         inputs_ready_signal,
  input  logic                                         ready_for_tile,
  output logic [AW-1:0]                                tile_a_idx,
  output logic [BW-1:0]                                tile_b_idx,
  output logic                                         busy,
  output logic                                         sweep_done
);

  feeder_state_e state_q;
  logic          rd_en_q;
  logic          issue_q;
  logic          done_q;
  logic          busy_q;
  logic [POLY_A_TILE_WIDTH-1:0][DATA_WIDTH-1:0] tile_a_q;
  logic [POLY_B_TILE_WIDTH-1:0][DATA_WIDTH-1:0] tile_b_q;

  logic          idx_advance;
  logic          idx_clear;
  logic          idx_last;
  logic [AW-1:0] a_idx;
  logic [BW-1:0] b_idx;

  // Indices move on completion of a non-final pair and snap back to zero while leaving DONE.
  assign idx_advance = (state_q == ST_WAIT) && ready_for_tile && !idx_last;
  assign idx_clear   = (state_q == ST_DONE);

  tile_idx_counter #(
    .NA(NA),
    .NB(NB),
    .AW(AW),
    .BW(BW)
  ) u_idx (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance_i(idx_advance),
    .clear_i  (idx_clear),
    .a_idx_o  (a_idx),
    .b_idx_o  (b_idx),
    .last_o   (idx_last)
  );

  // Outputs are set on entry to a state, so each one is high exactly while that state is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rd_en_q  <= 1'b0;
      issue_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      tile_a_q <= '0;
      tile_b_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_FETCH;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_FETCH: begin
          state_q <= ST_LOAD;
          rd_en_q <= 1'b0;
        end
        ST_LOAD: begin
          tile_a_q <= a_rd_data;
          tile_b_q <= b_rd_data;
          state_q  <= ST_ISSUE;
          issue_q  <= 1'b1;
        end
        ST_ISSUE: begin
          issue_q <= 1'b0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ready_for_tile) begin
            if (idx_last) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_FETCH;
              rd_en_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          rd_en_q <= 1'b0;
          issue_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a_rd_en             = rd_en_q;
  assign b_rd_en             = rd_en_q;
  assign a_rd_addr           = a_idx;
  assign b_rd_addr           = b_idx;
  assign tile_a_idx          = a_idx;
  assign tile_b_idx          = b_idx;
  assign tile_a              = tile_a_q;
  assign tile_b              = tile_b_q;
  assign inputs_ready_signal = issue_q;
  assign busy                = busy_q;
  assign sweep_done          = done_q;

endmodule

// File: tb/tb_poly_tile_feeder.sv
// Directed bench for poly_tile_feeder with a 2x2 tile sweep, memory and multiplier models.
module tb_poly_tile_feeder;

  localparam int DW = 64;
  localparam int TW = 8;

  logic                   clk;
  logic                   rst_n;
  logic                   start;
  logic                   a_rd_en, b_rd_en;
  logic [0:0]             a_rd_addr, b_rd_addr;
  logic [TW-1:0][DW-1:0]  a_rd_data, b_rd_data;
  logic [TW-1:0][DW-1:0]  tile_a, tile_b;
  logic                   inputs_ready_signal;
  logic                   ready_for_tile;
  logic [0:0]             tile_a_idx, tile_b_idx;
  logic                   busy;
  logic                   sweep_done;

  logic modelReady;
  logic forceReady;
  int   modelCnt;
  int   pulseCount;
  int   doneCount;
  int   checks;
  int   errors;

  typedef struct {
    int expA;
    int expB;
  } pair_t;

  typedef struct {
    bit injectIgnore;
    bit pokeStart;
    int expPulses;
  } scenario_t;

  pair_t     pairs[4];
  scenario_t scen[3];

  poly_tile_feeder #(
    .POLY_A_WIDTH     (16),
    .POLY_B_WIDTH     (16),
    .POLY_A_TILE_WIDTH(TW),
    .POLY_B_TILE_WIDTH(TW),
    .DATA_WIDTH       (DW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .a_rd_en            (a_rd_en),
    .b_rd_en            (b_rd_en),
    .a_rd_addr          (a_rd_addr),
    .b_rd_addr          (b_rd_addr),
    .a_rd_data          (a_rd_data),
    .b_rd_data          (b_rd_data),
    .tile_a             (tile_a),
    .tile_b             (tile_b),
    .inputs_ready_signal(inputs_ready_signal),
    .ready_for_tile     (ready_for_tile),
    .tile_a_idx         (tile_a_idx),
    .tile_b_idx         (tile_b_idx),
    .busy               (busy),
    .sweep_done         (sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ready_for_tile = modelReady | forceReady;

  // Synchronous coefficient memories with one cycle of read latency.
  initial begin
    a_rd_data = '0;
    b_rd_data = '0;
  end
  always @(posedge clk) begin
    if (a_rd_en)
      for (int l = 0; l < TW; l++) a_rd_data[l] <= DW'(int'(a_rd_addr) * 8 + l);
    if (b_rd_en)
      for (int l = 0; l < TW; l++) b_rd_data[l] <= DW'(100 + int'(b_rd_addr) * 8 + l);
  end

  // Multiplier model: completes a tile five cycles after each start pulse.
  initial begin
    modelReady = 1'b0;
    modelCnt   = 0;
  end
  always @(negedge clk) begin
    modelReady = 1'b0;
    if (!rst_n) begin
      modelCnt = 0;
    end else if (inputs_ready_signal) begin
      modelCnt = 5;
    end else if (modelCnt > 0) begin
      modelCnt = modelCnt - 1;
      if (modelCnt == 0) modelReady = 1'b1;
    end
  end

  initial begin
    pulseCount = 0;
    doneCount  = 0;
  end
  always @(posedge clk) begin
    if (inputs_ready_signal) pulseCount <= pulseCount + 1;
    if (sweep_done) doneCount <= doneCount + 1;
  end

  function automatic logic [TW-1:0][DW-1:0] expTileA(input int t);
    logic [TW-1:0][DW-1:0] v;
    for (int l = 0; l < TW; l++) v[l] = DW'(t * 8 + l);
    return v;
  endfunction

  function automatic logic [TW-1:0][DW-1:0] expTileB(input int t);
    logic [TW-1:0][DW-1:0] v;
    for (int l = 0; l < TW; l++) v[l] = DW'(100 + t * 8 + l);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout expected=event", name);
  endtask

  task automatic waitPulse(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (inputs_ready_signal) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) reportTimeout("waitPulse");
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_rden"}, {a_rd_en, b_rd_en}, 0);
    checkOutput({tag, "_issue"}, inputs_ready_signal, 0);
    checkOutput({tag, "_done"}, sweep_done, 0);
    checkOutput({tag, "_idx"}, {tile_a_idx, tile_b_idx}, 0);
    checkOutput({tag, "_tileA"}, tile_a, 0);
    checkOutput({tag, "_tileB"}, tile_b, 0);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first ISSUE.
  task automatic applyStimulus(input bit injectFetch, output int base, output int dbase);
    base  = pulseCount;
    dbase = doneCount;
    start = 1'b1;
    @(negedge clk);
    checkOutput("fetch_busy", busy, 1);
    checkOutput("fetch_rden", {a_rd_en, b_rd_en}, 2'b11);
    checkOutput("fetch_addr", {a_rd_addr, b_rd_addr}, 0);
    if (injectFetch) forceReady = 1'b1;
    start = 1'b0;
    @(negedge clk);
    forceReady = 1'b0;
    checkOutput("load_issue", inputs_ready_signal, 0);
    checkOutput("load_idx", {tile_a_idx, tile_b_idx}, 0);
    @(negedge clk);
    checkOutput("latency_issue", inputs_ready_signal, 1);
  endtask

  // Called at the negedge of the first ISSUE; returns at the negedge of the following IDLE.
  task automatic sweepBody(input bit injectIgnore, input bit pokeStart, input int expPulses,
                           input int base, input int dbase);
    bit ok;
    bit seen;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        waitPulse(ok);
        if (!ok) return;
      end
      checkOutput("pair_a_idx", tile_a_idx, pairs[i].expA);
      checkOutput("pair_b_idx", tile_b_idx, pairs[i].expB);
      checkOutput("pair_tileA", tile_a, expTileA(pairs[i].expA));
      checkOutput("pair_tileB", tile_b, expTileB(pairs[i].expB));
      if (injectIgnore) begin
        forceReady = 1'b1;
        @(negedge clk);
        forceReady = 1'b0;
        checkOutput("ignore_issue_idx", {tile_a_idx, tile_b_idx},
                    {1'(pairs[i].expA), 1'(pairs[i].expB)});
        checkOutput("ignore_issue_pulse", inputs_ready_signal, 0);
      end
      if (pokeStart) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("poke_busy", busy, 1);
        checkOutput("poke_pulse", inputs_ready_signal, 0);
      end
    end
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (sweep_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      reportTimeout("sweep_done");
      return;
    end
    checkOutput("done_busy", busy, 1);
    @(negedge clk);
    checkOutput("done_one_cycle", sweep_done, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_idx", {tile_a_idx, tile_b_idx}, 0);
    checkOutput("pulse_count", pulseCount - base, expPulses);
    checkOutput("done_count", doneCount - dbase, 1);
    if (pokeStart) begin
      @(negedge clk);
      checkOutput("poke_no_restart", busy, 0);
    end
  endtask

  initial begin
    int base, dbase;
    bit ok;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    forceReady = 1'b0;

    pairs[0] = '{expA: 0, expB: 0};
    pairs[1] = '{expA: 0, expB: 1};
    pairs[2] = '{expA: 1, expB: 0};
    pairs[3] = '{expA: 1, expB: 1};
    scen[0] = '{injectIgnore: 1'b0, pokeStart: 1'b0, expPulses: 4};
    scen[1] = '{injectIgnore: 1'b1, pokeStart: 1'b0, expPulses: 4};
    scen[2] = '{injectIgnore: 1'b0, pokeStart: 1'b1, expPulses: 4};

    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_no_start", busy, 0);

    for (int s = 0; s < 3; s++) begin
      applyStimulus(scen[s].injectIgnore, base, dbase);
      sweepBody(scen[s].injectIgnore, scen[s].pokeStart, scen[s].expPulses, base, dbase);
      @(negedge clk);
    end

    // Reset while waiting on pair (1,0).
    applyStimulus(1'b0, base, dbase);
    waitPulse(ok);
    if (ok) waitPulse(ok);
    if (ok) begin
      checkOutput("abort_pair", {tile_a_idx, tile_b_idx}, 2'b10);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkResetState("abort");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("abort_no_done", doneCount - dbase, 0);
      applyStimulus(1'b0, base, dbase);
      sweepBody(1'b0, 1'b0, 4, base, dbase);
      @(negedge clk);
    end

    // Start held high: back-to-back sweeps with a single IDLE cycle.
    base  = pulseCount;
    dbase = doneCount;
    start = 1'b1;
    @(negedge clk);
    checkOutput("hold_fetch_busy", busy, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("hold_issue", inputs_ready_signal, 1);
    sweepBody(1'b0, 1'b0, 4, base, dbase);
    @(negedge clk);
    checkOutput("hold_refetch_busy", busy, 1);
    checkOutput("hold_refetch_rden", a_rd_en, 1);
    checkOutput("hold_refetch_idx", {tile_a_idx, tile_b_idx}, 0);
    base  = pulseCount;
    dbase = doneCount;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("hold2_issue", inputs_ready_signal, 1);
    sweepBody(1'b0, 1'b0, 4, base, dbase);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
